// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

   localparam logic PWM_EDGE   = 1'b0;
   localparam logic PWM_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Default width of the counter; reset TOP is the all-ones value for a given width.
   localparam int unsigned PWM_WIDTH_DEFAULT = 7;
   localparam int unsigned PWM_TOP_RST_DEFAULT = (1 << PWM_WIDTH_DEFAULT) - 1;

   function automatic int unsigned pwm_top_rst(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: double-buffered duty and a registered compare against the shared count.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [WIDTH:0]   duty_i,
   input  logic             xfer_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             pwm_o
);

   logic [WIDTH:0] duty_sh_d, duty_sh_q;
   logic [WIDTH:0] duty_act_d, duty_act_q;
   logic           pwm_d, pwm_q;

   always_comb begin
      duty_sh_d  = wr_i ? duty_i : duty_sh_q;
      // A write landing on the transfer edge goes straight through to the active copy.
      duty_act_d = xfer_i ? duty_sh_d : duty_act_q;
      pwm_d      = en_i & ({1'b0, cnt_i} < duty_act_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         pwm_q      <= 1'b0;
      end else begin
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         pwm_q      <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned counter with shadowed period and mode,
// a period-start strobe, and CHANNELS compare channels.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = PWM_WIDTH_DEFAULT,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                mode_i,
   input  logic [WIDTH-1:0]    top_i,
   input  logic                wr_i,
   input  logic [SELW-1:0]     ch_sel_i,
   input  logic [WIDTH:0]      duty_i,
   output logic [CHANNELS-1:0] pwm_out_o,
   output logic                e_o,
   output logic [WIDTH-1:0]    cnt_o
);

   localparam logic [WIDTH-1:0] TOP_RST = WIDTH'(pwm_top_rst(WIDTH));

   logic [WIDTH-1:0] top_sh_q, top_act_d, top_act_q;
   logic             mode_sh_q, mode_act_d, mode_act_q;
   logic [WIDTH-1:0] cnt_d, cnt_q;
   dir_e             dir_d, dir_q;
   logic             e_d, e_q;
   logic             boundary, xfer;
   logic [WIDTH-1:0] turn_cnt;

   always_comb begin
      // Center mode turns at T-1 where T = max(TOP, 1).
      turn_cnt   = (top_act_q == '0) ? '0 : top_act_q - 1'b1;
      boundary   = (mode_act_q == PWM_EDGE) ? (cnt_q == top_act_q)
                                            : ((cnt_q == '0) && (dir_q == DIR_DOWN));
      xfer       = !en_i || boundary;
      top_act_d  = xfer ? top_sh_q : top_act_q;
      mode_act_d = xfer ? mode_sh_q : mode_act_q;
      e_d        = en_i & boundary;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      if (!en_i) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (mode_act_q == PWM_EDGE) begin
         cnt_d = boundary ? '0 : cnt_q + 1'b1;
         dir_d = DIR_UP;
      end else begin
         unique case (dir_q)
            DIR_UP: begin
               if (cnt_q >= turn_cnt) dir_d = DIR_DOWN;
               else                   cnt_d = cnt_q + 1'b1;
            end
            DIR_DOWN: begin
               if (cnt_q == '0) dir_d = DIR_UP;
               else             cnt_d = cnt_q - 1'b1;
            end
            default: dir_d = DIR_UP;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_sh_q   <= TOP_RST;
         top_act_q  <= TOP_RST;
         mode_sh_q  <= PWM_EDGE;
         mode_act_q <= PWM_EDGE;
         cnt_q      <= '0;
         dir_q      <= DIR_UP;
         e_q        <= 1'b0;
      end else begin
         top_sh_q   <= top_i;
         top_act_q  <= top_act_d;
         mode_sh_q  <= mode_i;
         mode_act_q <= mode_act_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         e_q        <= e_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic wr_ch;
      // Out-of-range selects match no channel and are dropped.
      assign wr_ch = wr_i && (32'(ch_sel_i) == c);

      pwm_channel #(
         .WIDTH(WIDTH)
      ) u_channel (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (en_i),
         .wr_i   (wr_ch),
         .duty_i (duty_i),
         .xfer_i (xfer),
         .cnt_i  (cnt_q),
         .pwm_o  (pwm_out_o[c])
      );
   end

   assign e_o   = e_q;
   assign cnt_o = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (WIDTH=7, CHANNELS=2, 2-bit channel select).
module tb_pwm_multi;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [6:0] top;
   logic       wr;
   logic [1:0] sel;
   logic [7:0] duty;
   logic [1:0] pwm_out;
   logic       e;
   logic [6:0] cnt;

   int vectors;
   int miscompares;
   int ctab [8] = '{0, 1, 2, 3, 3, 2, 1, 0};

   pwm_multi #(
      .WIDTH   (7),
      .CHANNELS(2),
      .SELW    (2)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .en_i     (en),
      .mode_i   (mode),
      .top_i    (top),
      .wr_i     (wr),
      .ch_sel_i (sel),
      .duty_i   (duty),
      .pwm_out_o(pwm_out),
      .e_o      (e),
      .cnt_o    (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Disable, load mode/top/duties through the shadows, then enable from CNT=0.
   task automatic start_run(input logic m, input logic [6:0] t, input logic [7:0] d0,
                            input logic [7:0] d1);
      en = 1'b0; mode = m; top = t;
      wr = 1'b1; sel = 2'd0; duty = d0;
      step();
      sel = 2'd1; duty = d1;
      step();
      wr = 1'b0;
      step();
      step();
      en = 1'b1;
   endtask

   task automatic test_reset();
      logic [9:0] exp;
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; top = 7'd9; wr = 1'b0; sel = 2'd0; duty = 8'd0;
      repeat (3) step();
      vectors++;
      if ({cnt, pwm_out, e} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_hold got %h want %h", {cnt, pwm_out, e}, 10'd0);
      end
      rst_n = 1'b1; en = 1'b1;
      repeat (12) step();
      // Reset TOP is 127, so the counter must not have wrapped at 9.
      exp = {7'd12, 2'b00, 1'b0};
      vectors++;
      if ({cnt, pwm_out, e} !== exp) begin
         miscompares++;
         $display("FAIL reset_top got %h want %h", {cnt, pwm_out, e}, exp);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({cnt, pwm_out, e} !== 10'd0) begin
         miscompares++;
         $display("FAIL async_reset got %h want %h", {cnt, pwm_out, e}, 10'd0);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_edge_double_buffer();
      logic [9:0] exp;
      int d;
      start_run(1'b0, 7'd9, 8'd3, 8'd0);
      for (int k = 1; k <= 40; k++) begin
         step();
         d = (k - 1 >= 30) ? 7 : 3;
         exp = {7'(k % 10), 1'b0, ((k - 1) % 10) < d, (k % 10) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL edge_dbuf k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
         wr = (k == 24); sel = 2'd0; duty = 8'd7;
      end
      wr = 1'b0;
   endtask

   task automatic test_boundary_write();
      logic [9:0] exp;
      int d;
      start_run(1'b0, 7'd9, 8'd3, 8'd2);
      for (int k = 1; k <= 30; k++) begin
         step();
         d = (k - 1 >= 10) ? 5 : 2;
         exp = {7'(k % 10), ((k - 1) % 10) < d, ((k - 1) % 10) < 3, (k % 10) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL boundary_wr k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
         wr = (k == 9); sel = 2'd1; duty = 8'd5;
      end
      wr = 1'b0;
   endtask

   task automatic test_limits();
      logic [9:0] exp;
      start_run(1'b0, 7'd9, 8'd3, 8'd0);
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = {7'(k % 10), 1'b0, ((k - 1) % 10) < 3, (k % 10) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL duty_zero k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
      start_run(1'b0, 7'd9, 8'd3, 8'd10);
      for (int k = 1; k <= 25; k++) begin
         step();
         exp = {7'(k % 10), 1'b1, ((k - 1) % 10) < 3, (k % 10) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL duty_full_badsel k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
         wr = (k == 5); sel = 2'd3; duty = 8'd0;
      end
      wr = 1'b0;
   endtask

   task automatic test_center();
      logic [9:0] exp;
      start_run(1'b1, 7'd4, 8'd1, 8'd0);
      for (int k = 1; k <= 24; k++) begin
         step();
         exp = {7'(ctab[k % 8]), 1'b0, ctab[(k - 1) % 8] < 1, (k % 8) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL center k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
      start_run(1'b1, 7'd4, 8'd4, 8'd0);
      for (int k = 1; k <= 16; k++) begin
         step();
         exp = {7'(ctab[k % 8]), 1'b0, 1'b1, (k % 8) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL center_full k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
   endtask

   task automatic test_en_toggle();
      logic [9:0] exp;
      start_run(1'b0, 7'd9, 8'd8, 8'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         exp = {7'(k % 10), 1'b0, ((k - 1) % 10) < 8, 1'b0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL en_pre k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
      en = 1'b0;
      step();
      vectors++;
      if ({cnt, pwm_out, e} !== 10'd0) begin
         miscompares++;
         $display("FAIL en_drop got %h want %h", {cnt, pwm_out, e}, 10'd0);
      end
      top = 7'd4; wr = 1'b1; sel = 2'd0; duty = 8'd2;
      step();
      wr = 1'b0;
      step();
      step();
      en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         step();
         exp = {7'(k % 5), 1'b0, ((k - 1) % 5) < 2, (k % 5) == 0};
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL en_resume k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
   endtask

   task automatic test_top_zero();
      logic [9:0] exp;
      start_run(1'b0, 7'd0, 8'd1, 8'd0);
      exp = {7'd0, 2'b01, 1'b1};
      for (int k = 1; k <= 10; k++) begin
         step();
         vectors++;
         if ({cnt, pwm_out, e} !== exp) begin
            miscompares++;
            $display("FAIL top_zero k=%0d got %h want %h", k, {cnt, pwm_out, e}, exp);
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_edge_double_buffer();
      test_boundary_write();
      test_limits();
      test_center();
      test_en_toggle();
      test_top_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
